// File: rtl/gate_vector_seq_if.sv
// -----------------------------------------------------------------------------
// gate_vector_seq_if
//
// Bundles every non-clock signal between the truth-table sequencer and the
// environment around it (the two-input gate model plus the controller that
// requests sweeps and reads the verdict).
//
// Signals
//   start      sweep request from the controller
//   a, b       stimulus driven to the gate model
//   and_g ..   seven gate-model responses to the current a/b
//   xnor_g
//   busy       sweep in progress
//   done       one-cycle end-of-sweep pulse
//   pass       last sweep had no mismatching vector
//   err_cnt    number of vectors in the last sweep with any mismatch (0..4)
//   err_mask   per-gate sticky failure flags, bit order:
//              [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor
//   vec_idx    index of the vector currently driven
//
// Modports
//   master     the sequencer (drives stimulus and verdict)
//   slave      the environment (drives start and the gate responses)
// -----------------------------------------------------------------------------
interface gate_vector_seq_if;

    // Sweep request.
    logic       start;

    // Stimulus to the gate model.
    logic       a;
    logic       b;

    // Gate-model responses.
    logic       and_g;
    logic       or_g;
    logic       not_g;
    logic       nand_g;
    logic       nor_g;
    logic       xor_g;
    logic       xnor_g;

    // Status and verdict.
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_cnt;
    logic [6:0] err_mask;
    logic [1:0] vec_idx;

    modport master (
        input  start,
        input  and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g,
        output a, b,
        output busy, done, pass, err_cnt, err_mask, vec_idx
    );

    modport slave (
        output start,
        output and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g,
        input  a, b,
        input  busy, done, pass, err_cnt, err_mask, vec_idx
    );

endinterface : gate_vector_seq_if

// File: rtl/gate_vector_seq.sv
// -----------------------------------------------------------------------------
// gate_vector_seq
//
// Truth-table sweeper for a downstream two-input gate model. On a start
// request it walks the four input vectors 00, 01, 10, 11 (a = vec_idx[1],
// b = vec_idx[0]), holds each one for HOLD_CYCLES clocks, and in the last
// cycle of each hold compares the seven gate responses against the ideal
// AND/OR/NOT(a)/NAND/NOR/XOR/XNOR values. Mismatches accumulate into a
// per-gate sticky mask and a per-vector error count; a one-cycle done pulse
// ends the sweep together with the pass verdict.
//
// Parameters
//   HOLD_CYCLES  clocks each vector is held on a/b (2..255)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          gate_vector_seq_if.master (start, a/b, gate responses,
//                busy, done, pass, err_cnt, err_mask, vec_idx)
//
// Timing
//   Edge E0 samples start. Each vector spends HOLD_CYCLES-1 cycles in DRIVE
//   and one cycle in SAMPLE, so done is high in the cycle following edge
//   E0 + 4*HOLD_CYCLES. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module gate_vector_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_vector_seq_if.master bus
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guard: an out-of-range HOLD_CYCLES pulls in
    // a module that does not exist, so the build stops instead of producing
    // a sequencer with a wrapped hold counter.
    // -------------------------------------------------------------------------
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
        gate_vector_seq_hold_cycles_out_of_range u_bad_param ();
    end

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // DRIVE lasts HOLD_CYCLES-1 cycles; the counter starts at 0, so the last
    // DRIVE cycle is the one where it reads HOLD_CYCLES-2.
    localparam logic [7:0] DRIVE_LAST = 8'(HOLD_CYCLES - 2);

    localparam logic [1:0] LAST_VEC = 2'd3;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] hold_cnt;
    logic [1:0] vec_idx_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_cnt_q;
    logic [6:0] err_mask_q;

    // -------------------------------------------------------------------------
    // Response checking
    // -------------------------------------------------------------------------
    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] mismatch;
    logic       vec_fail;
    logic [2:0] err_cnt_nxt;
    logic [1:0] vec_idx_inc;
    logic       hold_last;
    logic       last_vec;

    // Ideal responses for the vector currently on a/b; the comparison uses
    // the registered stimulus, which is exactly what the gate model sees.
    always_comb begin
        expected[0] =   a_q & b_q;
        expected[1] =   a_q | b_q;
        expected[2] =  ~a_q;
        expected[3] = ~(a_q & b_q);
        expected[4] = ~(a_q | b_q);
        expected[5] =   a_q ^ b_q;
        expected[6] = ~(a_q ^ b_q);
    end

    assign observed = {bus.xnor_g, bus.xor_g, bus.nor_g, bus.nand_g,
                       bus.not_g,  bus.or_g,  bus.and_g};

    assign mismatch    = expected ^ observed;
    assign vec_fail    = |mismatch;

    // Four vectors into a 3-bit count: at most one increment per vector, so
    // the count tops out at 4 and can never wrap.
    assign err_cnt_nxt = err_cnt_q + {2'b00, vec_fail};

    assign vec_idx_inc = vec_idx_q + 2'd1;
    assign hold_last   = (hold_cnt == DRIVE_LAST);
    assign last_vec    = (vec_idx_q == LAST_VEC);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: next state gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_DRIVE;
            ST_DRIVE:  if (hold_last) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every flop in this block, control and datapath alike, is cleared
    // by the asynchronous reset; there is no storage array, so nothing is
    // left to come up undefined after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= 8'd0;
            vec_idx_q  <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 3'd0;
            err_mask_q <= 7'd0;
        end else begin
            // done is a single-cycle strobe; only the SAMPLE->DONE
            // transition raises it.
            done_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Stimulus parked at 00 while idle; results of the last
                    // sweep are held until a new start is accepted.
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    if (bus.start) begin
                        vec_idx_q  <= 2'd0;
                        hold_cnt   <= 8'd0;
                        err_cnt_q  <= 3'd0;
                        err_mask_q <= 7'd0;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                ST_DRIVE: begin
                    hold_cnt <= hold_cnt + 8'd1;
                end

                ST_SAMPLE: begin
                    // Last cycle of the hold: fold this vector's result in.
                    hold_cnt   <= 8'd0;
                    err_cnt_q  <= err_cnt_nxt;
                    err_mask_q <= err_mask_q | mismatch;
                    if (last_vec) begin
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // Verdict includes the vector being sampled right now.
                        pass_q <= (err_cnt_nxt == 3'd0);
                    end else begin
                        vec_idx_q <= vec_idx_inc;
                        a_q       <= vec_idx_inc[1];
                        b_q       <= vec_idx_inc[0];
                    end
                end

                ST_DONE: begin
                    vec_idx_q <= 2'd0;
                end

                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all flop-driven)
    // -------------------------------------------------------------------------
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.err_mask = err_mask_q;
    assign bus.vec_idx  = vec_idx_q;

endmodule : gate_vector_seq

// File: tb/tb_gate_vector_seq.sv
// -----------------------------------------------------------------------------
// tb_gate_vector_seq
//
// Two sequencers share clock and reset: one with HOLD_CYCLES=4, one with
// HOLD_CYCLES=2. Each drives its own behavioural gate model whose faults are
// described by a force-to-zero mask and an invert mask. Issuing a sweep
// pushes the expected verdict and timing into a per-instance queue; a
// forked monitor compares every cycle against the queue head.
// -----------------------------------------------------------------------------
module tb_gate_vector_seq;

    localparam int HC0 = 4;
    localparam int HC1 = 2;

    typedef struct {
        int         e0;        // edge number that samples start
        int         done_cyc;  // edge after which done must be high
        logic       pass;
        logic [2:0] err_cnt;
        logic [6:0] err_mask;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;

    gate_vector_seq_if bus0 ();
    gate_vector_seq_if bus1 ();

    logic [6:0]  force0 [2];
    logic [6:0]  invert [2];
    exp_t        exp_q  [2][$];
    logic [10:0] last_res [2];   // {pass, err_cnt, err_mask} of the last sweep

    int n_pass;
    int n_total;

    gate_vector_seq #(.HOLD_CYCLES(HC0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gate_vector_seq #(.HOLD_CYCLES(HC1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural gate model: ideal truth table, then faults applied.
    function automatic logic [6:0] ideal(input logic a, input logic b);
        int ia = int'(a);
        int ib = int'(b);
        logic [6:0] r;
        r[0] = (ia * ib) == 1;
        r[1] = (ia + ib) > 0;
        r[2] = ia == 0;
        r[3] = (ia * ib) == 0;
        r[4] = (ia + ib) == 0;
        r[5] = (ia + ib) == 1;
        r[6] = (ia + ib) != 1;
        return r;
    endfunction

    function automatic logic [6:0] gate_model(input logic a, input logic b,
                                              input logic [6:0] f0,
                                              input logic [6:0] inv);
        return (ideal(a, b) & ~f0) ^ inv;
    endfunction

    assign {bus0.xnor_g, bus0.xor_g, bus0.nor_g, bus0.nand_g,
            bus0.not_g,  bus0.or_g,  bus0.and_g} = gate_model(bus0.a, bus0.b, force0[0], invert[0]);
    assign {bus1.xnor_g, bus1.xor_g, bus1.nor_g, bus1.nand_g,
            bus1.not_g,  bus1.or_g,  bus1.and_g} = gate_model(bus1.a, bus1.b, force0[1], invert[1]);

    function automatic int hold_of(input int g);
        return (g == 0) ? HC0 : HC1;
    endfunction

    // {a, b, busy, done, pass, err_cnt[2:0], err_mask[6:0], vec_idx[1:0]}
    function automatic logic [16:0] outs(input int g);
        if (g == 0)
            return {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass,
                    bus0.err_cnt, bus0.err_mask, bus0.vec_idx};
        return {bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass,
                bus1.err_cnt, bus1.err_mask, bus1.vec_idx};
    endfunction

    task automatic set_start(input int g, input logic v);
        if (g == 0) bus0.start = v;
        else        bus1.start = v;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, want);
    endtask

    // Reference verdict for one sweep: walk the four vectors and count the
    // ones where the faulty model differs from the ideal table.
    task automatic ref_sweep(input logic [6:0] f0, input logic [6:0] inv, output exp_t e);
        e.err_cnt  = 3'd0;
        e.err_mask = 7'd0;
        for (int v = 0; v < 4; v++) begin
            logic [6:0] diff;
            diff = ideal(v[1], v[0]) ^ gate_model(v[1], v[0], f0, inv);
            if (diff != 7'd0) e.err_cnt = e.err_cnt + 3'd1;
            e.err_mask = e.err_mask | diff;
        end
        e.pass = (e.err_cnt == 3'd0);
    endtask

    task automatic mon_inst(input int g);
        logic [16:0] o;
        logic        have, in_win, exp_done;
        exp_t        e;
        int          h, k;
        logic [1:0]  v;
        o        = outs(g);
        h        = hold_of(g);
        have     = exp_q[g].size() != 0;
        in_win   = 1'b0;
        exp_done = 1'b0;
        if (have) begin
            e        = exp_q[g][0];
            in_win   = (cyc >= e.e0) && (cyc < e.e0 + 4 * h);
            exp_done = (cyc == e.done_cyc);
        end
        check($sformatf("done_%0d", g), o[13], exp_done);
        if (exp_done) begin
            check($sformatf("verdict_%0d", g), o[12:2], {e.pass, e.err_cnt, e.err_mask});
            last_res[g] = {e.pass, e.err_cnt, e.err_mask};
            void'(exp_q[g].pop_front());
        end else if (have && cyc > e.done_cyc) begin
            void'(exp_q[g].pop_front());
        end
        if (in_win) begin
            k = cyc - e.e0;
            v = 2'(k / h);
            // {a, b, busy, vec_idx, pass}
            check($sformatf("drive_%0d", g), {o[16:14], o[1:0], o[12]},
                  {v[1], v[0], 1'b1, v, 1'b0});
        end else begin
            // {a, b, busy, pass, err_cnt, err_mask}
            check($sformatf("idle_%0d", g), {o[16:14], o[12:2]}, {3'b000, last_res[g]});
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_inst(0);
                mon_inst(1);
            end
        end
    endtask

    // Issue one accepted sweep; returns the edge number that samples start.
    task automatic sweep(input int g, input logic [6:0] f0, input logic [6:0] inv, output int e0);
        exp_t e;
        @(negedge clk);
        force0[g] = f0;
        invert[g] = inv;
        ref_sweep(f0, inv, e);
        e.e0       = cyc + 1;
        e.done_cyc = e.e0 + 4 * hold_of(g);
        e0         = e.e0;
        exp_q[g].push_back(e);
        set_start(g, 1'b1);
        @(negedge clk);
        set_start(g, 1'b0);
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (exp_q[g].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("sweep_timeout_%0d", g), exp_q[g].size(), 0);
        exp_q[g].delete();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_start(input int g);
        set_start(g, 1'b1);
        @(negedge clk);
        set_start(g, 1'b0);
    endtask

    initial begin
        int e0;
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        bus0.start  = 1'b0;
        bus1.start  = 1'b0;
        for (int g = 0; g < 2; g++) begin
            force0[g]   = 7'd0;
            invert[g]   = 7'd0;
            last_res[g] = 11'd0;
        end

        repeat (3) @(negedge clk);
        check("reset_outs_0", outs(0), 17'd0);
        check("reset_outs_1", outs(1), 17'd0);
        rst_n = 1'b1;

        fork
            monitor();
        join_none

        // Correct model, H=4 then H=2.
        sweep(0, 7'd0, 7'd0, e0);         wait_idle(0);
        sweep(1, 7'd0, 7'd0, e0);         wait_idle(1);

        // and_g stuck at 0; xor_g inverted.
        sweep(0, 7'b0000001, 7'd0, e0);   wait_idle(0);
        sweep(0, 7'd0, 7'b0100000, e0);   wait_idle(0);
        sweep(1, 7'b0000001, 7'd0, e0);   wait_idle(1);

        // start re-asserted during DRIVE and during the DONE cycle.
        sweep(0, 7'd0, 7'd0, e0);
        wait_cyc(e0 + 1);
        pulse_start(0);
        wait_cyc(e0 + 4 * HC0);
        pulse_start(0);
        wait_idle(0);
        repeat (4) @(negedge clk);

        // Asynchronous reset while vector 2 is driven.
        sweep(0, 7'b0001000, 7'd0, e0);
        wait_cyc(e0 + 2 * HC0 + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_0", outs(0), 17'd0);
        check("async_reset_1", outs(1), 17'd0);
        for (int g = 0; g < 2; g++) begin
            exp_q[g].delete();
            last_res[g] = 11'd0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 7'd0, 7'd0, e0);         wait_idle(0);

        // Randomized faults, instances and idle gaps.
        for (int i = 0; i < 16; i++) begin
            int         g;
            logic [6:0] f0, inv;
            g   = int'($urandom_range(0, 1));
            f0  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            inv = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep(g, f0, inv, e0);
            wait_idle(g);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_gate_vector_seq

// File: doc/gate_vector_seq.md
GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, clock cycles each input vector is held on a/b; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-005 a, b  output  1 each  stimulus driven to the downstream two-input gate model.
REQ-006 and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g  input  1 each  gate-model responses.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse at sweep end.
REQ-009 pass  output  1  high when the last sweep had zero mismatching vectors.
REQ-010 err_cnt  output  3  number of vectors in the last sweep with at least one mismatch (0..4).
REQ-011 err_mask  output  7  sticky per-gate failure flags: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor.
REQ-012 vec_idx  output  2  index of the vector currently driven.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: a=b=0, busy=0; start=1 at an edge SHALL move to DRIVE with vec_idx=0, hold counter=0, err_cnt=0, err_mask=0, pass=0.
REQ-016 Vector order SHALL be a=vec_idx[1], b=vec_idx[0], giving 00, 01, 10, 11.
REQ-017 DRIVE: hold a/b; hold counter increments each cycle; after HOLD_CYCLES-1 cycles, go to SAMPLE.
REQ-018 SAMPLE: on exit, compare the seven inputs with expected a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b); OR mismatches into err_mask; increment err_cnt by 1 if any bit mismatches.
REQ-019 SAMPLE exit: vec_idx<3 -> vec_idx+1, counter cleared, DRIVE; vec_idx==3 -> DONE.
REQ-020 a/b SHALL stay stable for exactly HOLD_CYCLES cycles per vector, with the comparison taken in the last cycle.
REQ-021 DONE: done=1 for one cycle, busy=0, pass=(err_cnt==0 including the final vector); next state IDLE.
REQ-022 Latency: done SHALL be high in the cycle following the 4*HOLD_CYCLES-th edge after the edge that sampled start.
REQ-023 busy SHALL be 1 in DRIVE and SAMPLE only.
REQ-024 start SHALL be ignored in DRIVE, SAMPLE and DONE; no queuing.
REQ-025 pass, err_cnt and err_mask SHALL hold their values from the end of a sweep until the next accepted start.
REQ-026 err_cnt SHALL saturate at 4 by construction and never wrap.

Reset
REQ-027 rst_n low SHALL, asynchronously and at any state including mid-sweep, force: IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, err_mask=0, vec_idx=0, hold counter=0.
REQ-028 After rst_n deasserts, the first accepted start SHALL begin a fresh sweep from vector 00.

Verification
REQ-029 Correct gate model, HOLD_CYCLES=4, start pulse: a/b = 00, 01, 10, 11, each held 4 cycles -> done pulse 16 edges after start, pass=1, err_cnt=0, err_mask=0000000.
REQ-030 and_g stuck at 0 -> only vector 11 fails -> err_cnt=1, err_mask=0000001, pass=0.
REQ-031 xor_g inverted -> all four vectors fail -> err_cnt=4, err_mask=0100000, pass=0.
REQ-032 start re-asserted during DRIVE and during the DONE cycle -> no restart, sweep completes unchanged, exactly one done pulse, and the state returns to IDLE.
REQ-033 rst_n pulsed low while vec_idx=2 -> all outputs zero immediately, without waiting for a clock edge; a new start gives a full correct 4-vector sweep with pass=1.
REQ-034 HOLD_CYCLES=2 -> each vector held 2 cycles, done 8 edges after start, and results are the same as REQ-029.
